uart_rx_oversampled: RTL and testbench

// - UART receive front end feeding the RX FIFO of the loopback controller: converts the async serial

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_oversampled.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART types, constants and baud divider helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_e;

    // Clocks per oversample tick; integer division truncates toward a faster tick.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module   : uart_baud_tick
//  Brief    : Free-running divider producing a 1-cycle tick every DIV clocks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
// ============================================================================
//  Module   : uart_rx_oversampled
//  Brief    : 8N1 UART receiver, oversampled with 3-sample majority vote,
//             valid/ready byte output with framing-error and overrun pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_div = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int c_sw  = $clog2(OVERSAMPLE);
    localparam int c_bw  = $clog2(DATA_BITS);

    localparam logic [c_sw-1:0] c_s_lo   = c_sw'(OVERSAMPLE / 2 - 1);
    localparam logic [c_sw-1:0] c_s_mid  = c_sw'(OVERSAMPLE / 2);
    localparam logic [c_sw-1:0] c_s_hi   = c_sw'(OVERSAMPLE / 2 + 1);
    localparam logic [c_sw-1:0] c_s_last = c_sw'(OVERSAMPLE - 1);
    localparam logic [c_bw-1:0] c_last_bit = c_bw'(DATA_BITS - 1);

    generate
        if (c_div < 2 || (OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_param_check
            $fatal(1, "uart_rx_oversampled: DIV must be >= 2 and OVERSAMPLE even and >= 8");
        end
    endgenerate

    logic                 w_tick;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    uart_rx_state_e       r_state;
    uart_rx_state_e       w_next_state;
    logic [c_sw-1:0]      r_s;
    logic [c_bw-1:0]      r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [1:0]           r_vote;
    logic                 w_maj;
    logic                 w_centre;
    logic                 w_busy;
    logic                 w_commit;
    logic                 w_frame_bad;
    logic                 w_shift_en;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    uart_baud_tick #(
        .DIV (c_div)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Third vote is the live sample taken on the centre-decision tick itself.
    assign w_maj    = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_rx_sync) | (r_vote[1] & r_rx_sync);
    assign w_centre = w_tick && (r_s == c_s_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_tick && !r_rx_sync) w_next_state = START;
            START:   if (w_centre) w_next_state = w_maj ? IDLE : DATA;
            DATA:    if (w_centre && (r_bit_idx == c_last_bit)) w_next_state = STOP;
            STOP:    if (w_centre) w_next_state = w_maj ? IDLE : BREAK;
            BREAK:   if (w_tick && r_rx_sync) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != IDLE);
        w_commit    = (r_state == STOP) && w_centre && w_maj;
        w_frame_bad = (r_state == STOP) && w_centre && !w_maj;
        w_shift_en  = (r_state == DATA) && w_centre;
    end

    // Sample counter wraps every OVERSAMPLE ticks, so after the start-bit
    // decision each later centre lands exactly one bit period on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_vote    <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_s       <= '0;
                r_bit_idx <= '0;
            end else if (w_tick) begin
                r_s <= (r_s == c_s_last) ? '0 : r_s + 1'b1;
                if (r_s == c_s_lo)  r_vote[0] <= r_rx_sync;
                if (r_s == c_s_mid) r_vote[1] <= r_rx_sync;
            end
            if (w_shift_en) begin
                r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_overrun   <= w_commit && r_valid && !m_ready;
            if (w_commit && (!r_valid || m_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && m_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_data    = r_data;
    assign m_valid   = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
// ============================================================================
//  Module   : tb_uart_rx_oversampled
//  Brief    : Directed and randomized serial frames against a byte-level model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_oversampled;

    localparam real c_bit_ns = 1.0e9 / 115200.0;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         exp_fe = 0;
    int         exp_ov = 0;
    realtime    rise_t = 0;
    logic       prev_valid = 1'b0;
    bit         model_ready = 1'b1;
    bit         model_pending = 1'b0;

    always #10 clk = ~clk;

    uart_rx_oversampled #(
        .CLK_FREQ   (50_000_000),
        .BAUD_RATE  (115_200),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (m_valid && !prev_valid) rise_t = $realtime;
        end
        prev_valid = m_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Byte-level model: bad stop -> framing error; good byte while one is held
    // unconsumed -> overrun and dropped; otherwise the byte is delivered in order.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_fe++;
        end else if (!model_ready && model_pending) begin
            exp_ov++;
        end else begin
            exp_q.push_back(b);
            if (!model_ready) model_pending = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input real bit_ns, input bit stop_val);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    task automatic idle_bits(input real n);
        rx = 1'b1;
        #(n * c_bit_ns);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        chk({tag, "_ferr"}, fe_cnt, exp_fe);
        chk({tag, "_ovr"}, ov_cnt, exp_ov);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        realtime    t0;
        real        lat;
        real        sc;
        logic [7:0] rb;
        logic [7:0] b2b[3];
        real        scales[2];

        b2b    = '{8'h00, 8'hFF, 8'h5A};
        scales = '{1.03, 0.97};

        // Reset state
        #90;
        @(negedge clk);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // Single byte with latency check
        t0 = $realtime;
        send_byte(8'h41, c_bit_ns, 1'b1);
        model_frame(8'h41, 1'b1);
        idle_bits(1);
        lat = (rise_t - t0) / c_bit_ns;
        chk("lat_41", {31'd0, (lat > 9.0 && lat < 10.0)}, 32'd1);
        check_stream("b41");

        // Start-bit glitch is rejected
        rx = 1'b0;
        #1600;
        @(negedge clk);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        #400;
        rx = 1'b1;
        #(2.0 * c_bit_ns);
        @(negedge clk);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h42, c_bit_ns, 1'b1);
        model_frame(8'h42, 1'b1);
        idle_bits(1);
        check_stream("b42");

        // Framing error, held-low line, then recovery
        send_byte(8'h55, c_bit_ns, 1'b0);
        model_frame(8'h55, 1'b0);
        #(3.0 * c_bit_ns);
        @(negedge clk);
        chk("break_busy", {31'd0, busy}, 32'd1);
        idle_bits(1);
        send_byte(8'hA5, c_bit_ns, 1'b1);
        model_frame(8'hA5, 1'b1);
        idle_bits(1);
        check_stream("brk");

        // Overrun while consumer stalls
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        model_ready = 1'b0;
        send_byte(8'h11, c_bit_ns, 1'b1);
        model_frame(8'h11, 1'b1);
        idle_bits(1);
        send_byte(8'h22, c_bit_ns, 1'b1);
        model_frame(8'h22, 1'b1);
        idle_bits(1);
        @(negedge clk);
        chk("ovr_valid", {31'd0, m_valid}, 32'd1);
        chk("ovr_data", {24'd0, m_data}, 32'h11);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        model_ready = 1'b1;
        model_pending = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_drain", {31'd0, m_valid}, 32'd0);
        check_stream("ovr");

        // Back-to-back frames at +3% and -3% bit period
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 3; k++) begin
                send_byte(b2b[k], c_bit_ns * scales[s], 1'b1);
                model_frame(b2b[k], 1'b1);
            end
            idle_bits(1);
        end
        check_stream("b2b");

        // Random bytes at random baud within +/-2%
        for (int k = 0; k < 2; k++) begin
            rb = 8'($urandom);
            sc = 0.98 + real'($urandom_range(0, 40)) / 1000.0;
            send_byte(rb, c_bit_ns * sc, 1'b1);
            model_frame(rb, 1'b1);
            idle_bits(real'($urandom_range(1, 2)));
        end
        check_stream("rnd");

        // Reset during data bit 4 of 0xC3
        fork
            send_byte(8'hC3, c_bit_ns, 1'b1);
            begin
                #(5.5 * c_bit_ns);
                @(negedge clk);
                chk("prerst_busy", {31'd0, busy}, 32'd1);
                rst_n = 1'b0;
                #200;
                @(negedge clk);
                chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
                chk("midrst_m_data", {24'd0, m_data}, 32'd0);
                chk("midrst_busy", {31'd0, busy}, 32'd0);
                chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
                chk("midrst_overrun", {31'd0, overrun}, 32'd0);
            end
        join
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle_bits(1);
        send_byte(8'h3C, c_bit_ns, 1'b1);
        model_frame(8'h3C, 1'b1);
        idle_bits(1);
        check_stream("rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
